// File: rtl/pzbcm_rr_grant_arbiter_if.sv
// Request/grant bundle between N requesters and the round-robin grant arbiter.
// The master modport is the requester side. The slave modport is the arbiter side.
interface pzbcm_rr_grant_arbiter_if #(
   parameter int N = 2
);
   localparam int BINARY_WIDTH = (N >= 2) ? $clog2(N) : 1;

   logic [N-1:0]            i_request;
   logic                    i_free;
   logic [N-1:0]            o_grant;
   logic [BINARY_WIDTH-1:0] o_grant_index;
   logic                    o_busy;

   modport master (
      output i_request,
      output i_free,
      input  o_grant,
      input  o_grant_index,
      input  o_busy
   );

   modport slave (
      input  i_request,
      input  i_free,
      output o_grant,
      output o_grant_index,
      output o_busy
   );
endinterface

// File: rtl/pzbcm_rr_grant_arbiter.sv
// Registered round-robin arbiter. A grant stays locked until its owner pulses i_free.
// The releasing owner then drops to lowest priority.
module pzbcm_rr_grant_arbiter #(
   parameter int N = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   pzbcm_rr_grant_arbiter_if.slave  arb_if
);
   localparam int BINARY_WIDTH = (N >= 2) ? $clog2(N) : 1;

   typedef enum logic {
      IDLE,
      GRANTED
   } state_t;

   state_t                  state_q, state_d;
   logic [N-1:0]            grant_q, grant_d;
   logic [BINARY_WIDTH-1:0] index_q, index_d;
   logic [BINARY_WIDTH-1:0] last_q, last_d;

   logic [N-1:0]            request;
   logic [N-1:0]            masked;
   logic [N-1:0]            next_grant;
   logic [BINARY_WIDTH-1:0] next_index;
   logic                    any_request;

   function automatic logic [N-1:0] lowest_set(input logic [N-1:0] v);
      return v & (~v + N'(1));
   endfunction

   function automatic logic [BINARY_WIDTH-1:0] onehot_to_binary(input logic [N-1:0] oh);
      logic [BINARY_WIDTH-1:0] b;
      b = '0;
      for (int i = 0; i < N; i++) begin
         if (oh[i]) b = b | BINARY_WIDTH'(i);
      end
      return b;
   endfunction

   // Keeps only the requesters strictly above the last owner: the first pass of the wrap-around search.
   function automatic logic [N-1:0] mask_above(input logic [N-1:0] v,
                                               input logic [BINARY_WIDTH-1:0] last);
      logic [N-1:0] m;
      for (int i = 0; i < N; i++) begin
         m[i] = (i > int'(last)) ? v[i] : 1'b0;
      end
      return m;
   endfunction

   always_comb begin
      request     = arb_if.i_request;
      any_request = |request;
      masked      = mask_above(request, last_q);
      next_grant  = (|masked) ? lowest_set(masked) : lowest_set(request);
      next_index  = onehot_to_binary(next_grant);

      state_d = state_q;
      grant_d = grant_q;
      index_d = index_q;
      last_d  = last_q;

      case (state_q)
         IDLE: begin
            if (any_request) begin
               state_d = GRANTED;
               grant_d = next_grant;
               index_d = next_index;
               last_d  = next_index;
            end
         end
         GRANTED: begin
            // Without i_free the grant is locked, whatever the requests do.
            if (arb_if.i_free) begin
               if (any_request) begin
                  grant_d = next_grant;
                  index_d = next_index;
                  last_d  = next_index;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         index_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         index_q <= index_d;
      end
   end

   generate
      if (N > 1) begin : g_pointer
         // Starting at N-1 gives requester 0 first priority after reset.
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) last_q <= BINARY_WIDTH'(N - 1);
            else       last_q <= last_d;
         end
      end else begin : g_no_pointer
         logic unused_last;
         assign unused_last = ^last_d;
         assign last_q      = '0;
      end
   endgenerate

   assign arb_if.o_grant       = grant_q;
   assign arb_if.o_grant_index = index_q;
   assign arb_if.o_busy        = |grant_q;
endmodule

// File: tb/tb_pzbcm_rr_grant_arbiter.sv
// Directed bench for the round-robin grant arbiter at N=4, N=5 and N=1.
module tb_pzbcm_rr_grant_arbiter;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   pzbcm_rr_grant_arbiter_if #(.N(4)) if4 ();
   pzbcm_rr_grant_arbiter_if #(.N(5)) if5 ();
   pzbcm_rr_grant_arbiter_if #(.N(1)) if1 ();

   pzbcm_rr_grant_arbiter #(.N(4)) u_arb4 (.i_clk(clk), .i_rst(rst), .arb_if(if4.slave));
   pzbcm_rr_grant_arbiter #(.N(5)) u_arb5 (.i_clk(clk), .i_rst(rst), .arb_if(if5.slave));
   pzbcm_rr_grant_arbiter #(.N(1)) u_arb1 (.i_clk(clk), .i_rst(rst), .arb_if(if1.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish want finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      if4.i_request = '0; if4.i_free = 1'b0;
      if5.i_request = '0; if5.i_free = 1'b0;
      if1.i_request = '0; if1.i_free = 1'b0;
      step();
      step();
      total++;
      if (if4.o_grant !== 4'b0000 || if4.o_grant_index !== 2'd0 || if4.o_busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_n4: got grant=%b idx=%0d busy=%b want 0000/0/0",
                  if4.o_grant, if4.o_grant_index, if4.o_busy);
      end
      total++;
      if (if5.o_grant !== 5'b00000 || if1.o_grant !== 1'b0 || if1.o_busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_n5_n1: got n5=%b n1=%b busy1=%b want 00000/0/0",
                  if5.o_grant, if1.o_grant, if1.o_busy);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single();
      if4.i_request = 4'b0100;
      step();
      total++;
      if (if4.o_grant !== 4'b0100 || if4.o_grant_index !== 2'd2 || if4.o_busy !== 1'b1) begin
         bad++;
         $display("FAIL single_grant: got grant=%b idx=%0d busy=%b want 0100/2/1",
                  if4.o_grant, if4.o_grant_index, if4.o_busy);
      end
      for (int k = 0; k < 3; k++) begin
         step();
         total++;
         if (if4.o_grant !== 4'b0100) begin
            bad++;
            $display("FAIL single_hold[%0d]: got %b want 0100", k, if4.o_grant);
         end
      end
      if4.i_request = 4'b0000;
      if4.i_free    = 1'b1;
      step();
      if4.i_free    = 1'b0;
      total++;
      if (if4.o_grant !== 4'b0000 || if4.o_busy !== 1'b0 || if4.o_grant_index !== 2'd2) begin
         bad++;
         $display("FAIL single_release: got grant=%b busy=%b idx=%0d want 0000/0/2",
                  if4.o_grant, if4.o_busy, if4.o_grant_index);
      end
   endtask

   task automatic test_rotation();
      logic [3:0] exp_g [5];
      logic [1:0] exp_i [5];
      exp_g[0] = 4'b0001; exp_i[0] = 2'd0;
      exp_g[1] = 4'b0010; exp_i[1] = 2'd1;
      exp_g[2] = 4'b0100; exp_i[2] = 2'd2;
      exp_g[3] = 4'b1000; exp_i[3] = 2'd3;
      exp_g[4] = 4'b0001; exp_i[4] = 2'd0;
      do_reset();
      if4.i_request = 4'b1111;
      step();
      for (int k = 0; k < 5; k++) begin
         total++;
         if (if4.o_grant !== exp_g[k] || if4.o_grant_index !== exp_i[k] || if4.o_busy !== 1'b1) begin
            bad++;
            $display("FAIL rotation[%0d]: got grant=%b idx=%0d busy=%b want %b/%0d/1",
                     k, if4.o_grant, if4.o_grant_index, if4.o_busy, exp_g[k], exp_i[k]);
         end
         if4.i_free = 1'b1;
         if (k == 4) if4.i_request = 4'b0000;
         step();
      end
      if4.i_free = 1'b0;
      total++;
      if (if4.o_grant !== 4'b0000 || if4.o_busy !== 1'b0) begin
         bad++;
         $display("FAIL rotation_end: got grant=%b busy=%b want 0000/0", if4.o_grant, if4.o_busy);
      end
   endtask

   task automatic test_wrap_n5();
      if5.i_request = 5'b01000;
      step();
      total++;
      if (if5.o_grant !== 5'b01000 || if5.o_grant_index !== 3'd3) begin
         bad++;
         $display("FAIL wrap_first: got grant=%b idx=%0d want 01000/3", if5.o_grant, if5.o_grant_index);
      end
      if5.i_request = 5'b01001;
      if5.i_free    = 1'b1;
      step();
      total++;
      if (if5.o_grant !== 5'b00001 || if5.o_grant_index !== 3'd0) begin
         bad++;
         $display("FAIL wrap_mask: got grant=%b idx=%0d want 00001/0", if5.o_grant, if5.o_grant_index);
      end
      if5.i_request = 5'b01000;
      step();
      total++;
      if (if5.o_grant !== 5'b01000 || if5.o_grant_index !== 3'd3) begin
         bad++;
         $display("FAIL wrap_next: got grant=%b idx=%0d want 01000/3", if5.o_grant, if5.o_grant_index);
      end
      if5.i_request = 5'b00000;
      step();
      if5.i_free = 1'b0;
      total++;
      if (if5.o_grant !== 5'b00000 || if5.o_busy !== 1'b0) begin
         bad++;
         $display("FAIL wrap_release: got grant=%b busy=%b want 00000/0", if5.o_grant, if5.o_busy);
      end
   endtask

   task automatic test_hold();
      int held_bad;
      if4.i_request = 4'b0010;
      step();
      total++;
      if (if4.o_grant !== 4'b0010 || if4.o_grant_index !== 2'd1) begin
         bad++;
         $display("FAIL hold_grant: got grant=%b idx=%0d want 0010/1", if4.o_grant, if4.o_grant_index);
      end
      if4.i_request = 4'b0001;
      held_bad = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         total++;
         if (if4.o_grant !== 4'b0010 || if4.o_grant_index !== 2'd1) begin
            bad++;
            held_bad++;
            if (held_bad < 3)
               $display("FAIL hold_cycle[%0d]: got grant=%b idx=%0d want 0010/1",
                        k, if4.o_grant, if4.o_grant_index);
         end
      end
      if4.i_free = 1'b1;
      step();
      total++;
      if (if4.o_grant !== 4'b0001 || if4.o_grant_index !== 2'd0) begin
         bad++;
         $display("FAIL hold_handoff: got grant=%b idx=%0d want 0001/0", if4.o_grant, if4.o_grant_index);
      end
      if4.i_request = 4'b0000;
      step();
      if4.i_free = 1'b0;
      total++;
      if (if4.o_grant !== 4'b0000) begin
         bad++;
         $display("FAIL hold_release: got %b want 0000", if4.o_grant);
      end
   endtask

   task automatic test_idle_free();
      if4.i_free = 1'b1;
      step();
      step();
      if4.i_free = 1'b0;
      total++;
      if (if4.o_grant !== 4'b0000 || if4.o_busy !== 1'b0 || if4.o_grant_index !== 2'd0) begin
         bad++;
         $display("FAIL idle_free: got grant=%b busy=%b idx=%0d want 0000/0/0",
                  if4.o_grant, if4.o_busy, if4.o_grant_index);
      end
   endtask

   task automatic test_mid_reset();
      if4.i_request = 4'b1000;
      step();
      total++;
      if (if4.o_grant !== 4'b1000 || if4.o_grant_index !== 2'd3) begin
         bad++;
         $display("FAIL midrst_pre: got grant=%b idx=%0d want 1000/3", if4.o_grant, if4.o_grant_index);
      end
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (if4.o_grant !== 4'b0000 || if4.o_busy !== 1'b0) begin
         bad++;
         $display("FAIL midrst_async: got grant=%b busy=%b want 0000/0", if4.o_grant, if4.o_busy);
      end
      if4.i_request = 4'b0000;
      #2;
      rst = 1'b0;
      if4.i_request = 4'b1001;
      step();
      total++;
      if (if4.o_grant !== 4'b0001 || if4.o_grant_index !== 2'd0 || if4.o_busy !== 1'b1) begin
         bad++;
         $display("FAIL midrst_after: got grant=%b idx=%0d busy=%b want 0001/0/1",
                  if4.o_grant, if4.o_grant_index, if4.o_busy);
      end
      if4.i_request = 4'b0000;
      if4.i_free    = 1'b1;
      step();
      if4.i_free    = 1'b0;
   endtask

   task automatic test_n1();
      if1.i_request = 1'b1;
      step();
      total++;
      if (if1.o_grant !== 1'b1 || if1.o_grant_index !== 1'b0 || if1.o_busy !== 1'b1) begin
         bad++;
         $display("FAIL n1_grant: got grant=%b idx=%b busy=%b want 1/0/1",
                  if1.o_grant, if1.o_grant_index, if1.o_busy);
      end
      if1.i_free = 1'b1;
      step();
      total++;
      if (if1.o_grant !== 1'b1) begin
         bad++;
         $display("FAIL n1_regrant: got %b want 1", if1.o_grant);
      end
      if1.i_request = 1'b0;
      step();
      if1.i_free = 1'b0;
      total++;
      if (if1.o_grant !== 1'b0 || if1.o_busy !== 1'b0 || if1.o_grant_index !== 1'b0) begin
         bad++;
         $display("FAIL n1_release: got grant=%b busy=%b idx=%b want 0/0/0",
                  if1.o_grant, if1.o_busy, if1.o_grant_index);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_single();
      test_rotation();
      test_wrap_n5();
      test_hold();
      test_idle_free();
      test_mid_reset();
      test_n1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pzbcm_rr_grant_arbiter.md
Name: pzbcm_rr_grant_arbiter

Overview:
- Registered round-robin arbiter for N requesters. Produces a one-hot grant vector and its binary index.
- Sits directly upstream of the team's one-hot helper: its masked request vector feeds the lowest-set-bit one-hot selection, and it consumes the resulting one-hot-to-binary conversion.
- A grant, once issued, is locked until the owner releases it. Priority then rotates so the releasing requester becomes lowest priority.

Parameters:
- N, 2, number of requesters (≥1).
- BINARY_WIDTH, derived ((N>=2) ? $clog2(N) : 1), width of o_grant_index. Local parameter, not overridable.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_request  input  N  per-requester request. A requester holds it high until granted.
- i_free  input  1  release pulse from the current grant owner. Sampled only while o_busy=1.
- o_grant  output  N  registered one-hot grant; all-zero when idle.
- o_grant_index  output  BINARY_WIDTH  binary index of o_grant. Holds its last value when idle.
- o_busy  output  1  high while a grant is held; equals |o_grant.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - o_grant=0, o_grant_index=0, o_busy=0.
  - Last-grant pointer L=N-1, so requester 0 has highest priority first.
  - Reset asserted mid-grant drops the grant immediately. No release is implied.
- State machine, two states:
  - IDLE→GRANTED: when |i_request=1. o_grant/o_grant_index/o_busy are valid on the next rising edge (latency 1 cycle from request to grant).
  - GRANTED→IDLE: on i_free=1 and no remaining request. The grant clears on that edge.
  - GRANTED→GRANTED (back-to-back): on i_free=1 with |i_request=1. The new grant is loaded on the same edge, giving zero idle cycles between owners.
  - GRANTED with i_free=0: grant, index and L hold regardless of i_request changes, including the owner deasserting its request.
- Priority:
  - Search order is L+1, L+2, …, N-1, 0, …, L (wrap-around). The first set request wins.
  - Implementation: mask = i_request & ~((2<<L)-1). If mask is nonzero, take the lowest set bit of mask; otherwise take the lowest set bit of i_request. Lowest-set-bit selection uses the team's one-hot helper.
  - The released owner's request in the same cycle as i_free is eligible, but only at lowest priority.
  - On each new grant: L ← index of the new grant, o_grant_index ← one-hot-to-binary of the new grant.
- i_free while IDLE: ignored, no state change.
- i_free and a new request in the same cycle: both take effect; the request is considered in the back-to-back path above.
- N=1:
  - o_grant[0] goes high one cycle after i_request[0] and clears on i_free.
  - o_grant_index is constant 0. The pointer logic is removed.
- o_grant must always be zero or one-hot. X-free after reset.

Test Plan:
- Reset then single request (N=4): i_request=4'b0100 at cycle 0 → o_grant=4'b0100, o_grant_index=2, o_busy=1 at cycle 1; holds until i_free.
- Round-robin rotation (N=4): hold i_request=4'b1111 and pulse i_free every grant. Required sequence:
  - grants 0001, 0010, 0100, 1000, 0001, with indices 0, 1, 2, 3, 0;
  - no idle cycle between grants.
- Wrap-around and masking (N=5): L=3 after granting index 3; i_request=5'b01001 with i_free → next grant 5'b00001 (index 0 beats index 3, which is lowest priority).
- Hold behaviour: grant index 1 (N=4); drop i_request[1] and raise i_request[0], with i_free=0 for 10 cycles → o_grant stays 4'b0010 all 10 cycles; after i_free, o_grant=4'b0001.
- Idle release and mid-grant reset: i_free pulsed while idle → outputs stay 0. Assert i_rst asynchronously while o_grant=4'b1000 → o_grant=0, o_busy=0 immediately; after reset release, i_request=4'b1001 → grant 4'b0001.
- N=1 degenerate: i_request=1 → o_grant=1, o_grant_index=0 next cycle; i_free with request still high → o_grant remains 1 (re-granted); request low plus i_free → o_grant=0.
